// File: rtl/parity_receiver.sv
// parity_receiver
//   Receives one serial frame: DATA_W data bits (MSB first) followed by a
//   single parity bit. It assembles the data word, computes the parity of the
//   received data bits and flags a mismatch against the received parity bit.
//
// Parameters
//   DATA_W     : data bits per frame (2..16)
//   ODD_PARITY : 0 = even parity, 1 = odd parity
//
// Ports
//   clock      : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   start      : frame-start request, only looked at in IDLE
//   serialin   : serial data line (data MSB first, then parity bit)
//   registerA  : assembled data word
//   parity     : XOR of the received data bits
//   parity_err : received parity bit differs from the expected one
//   done       : one-cycle frame-complete pulse
//   busy       : high while shifting data or checking parity
module parity_receiver #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              serialin,
  output logic [DATA_W-1:0] registerA,
  output logic              parity,
  output logic              parity_err,
  output logic              done,
  output logic              busy
);

  // Both counters must be able to hold the value DATA_W.
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic ODD_BIT = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PCHK  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [CNT_W-1:0] ones_cnt_reg;
  logic             last_bit;

  // The edge that shifts in the final data bit is the one taken while the
  // counter still reads DATA_W-1.
  assign last_bit = (bit_cnt_reg == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_next = IDLE;
    done       = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = start ? SHIFT : IDLE;
      end
      SHIFT: begin
        busy       = 1'b1;
        state_next = last_bit ? PCHK : SHIFT;
      end
      PCHK: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: result registers keep their values outside SHIFT/PCHK so the
  // last frame stays visible until the next one starts shifting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      registerA    <= '0;
      parity       <= 1'b0;
      parity_err   <= 1'b0;
      bit_cnt_reg  <= '0;
      ones_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            bit_cnt_reg  <= '0;
            ones_cnt_reg <= '0;
          end
        end
        SHIFT: begin
          registerA    <= {registerA[DATA_W-2:0], serialin};
          ones_cnt_reg <= ones_cnt_reg + CNT_W'(serialin);
          bit_cnt_reg  <= bit_cnt_reg + 1'b1;
          // Stale error from the previous frame is dropped once shifting begins.
          parity_err   <= 1'b0;
        end
        PCHK: begin
          parity     <= ones_cnt_reg[0];
          parity_err <= serialin ^ (ones_cnt_reg[0] ^ ODD_BIT);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_receiver.sv
module tb_parity_receiver;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         serialin = 1'b0;

  logic [W-1:0] reg_e, reg_o;
  logic         par_e, par_o, err_e, err_o, done_e, done_o, busy_e, busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  always #5 clock = ~clock;

  parity_receiver #(.DATA_W(W), .ODD_PARITY(0)) dut_even (
    .clock(clock), .reset_n(reset_n), .start(start), .serialin(serialin),
    .registerA(reg_e), .parity(par_e), .parity_err(err_e),
    .done(done_e), .busy(busy_e)
  );

  parity_receiver #(.DATA_W(W), .ODD_PARITY(1)) dut_odd (
    .clock(clock), .reset_n(reset_n), .start(start), .serialin(serialin),
    .registerA(reg_o), .parity(par_o), .parity_err(err_o),
    .done(done_o), .busy(busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pos = -1 when idle, otherwise number of edges since the start edge.
  // registerA is simply the last W data bits received since reset.
  int   pos;
  bit   hist[$];
  logic exp_par, exp_err_e, exp_err_o;

  task automatic model_reset();
    pos = -1;
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
    exp_par   = 1'b0;
    exp_err_e = 1'b0;
    exp_err_o = 1'b0;
  endtask

  function automatic logic [W-1:0] exp_reg();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[W-1-i] = hist[i];
    return r;
  endfunction

  initial begin
    int ones;
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else if (pos == W + 1) begin
        pos = -1;
      end else if (pos >= 0) begin
        pos++;
        if (pos <= W) begin
          if (pos == 1) begin
            exp_err_e = 1'b0;
            exp_err_o = 1'b0;
          end
          hist.push_back(serialin);
          if (hist.size() > W) void'(hist.pop_front());
        end else begin
          ones = 0;
          for (int i = 0; i < W; i++) ones += int'(hist[i]);
          exp_par   = logic'(ones % 2);
          exp_err_e = serialin ^ exp_par;
          exp_err_o = serialin ^ exp_par ^ 1'b1;
        end
      end else if (start) begin
        pos = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clock);
      check("done_even", done_e, (pos == W + 1));
      check("done_odd",  done_o, (pos == W + 1));
      check("busy_even", busy_e, (pos >= 0 && pos <= W));
      check("busy_odd",  busy_o, (pos >= 0 && pos <= W));
      check("regA_even", reg_e, exp_reg());
      check("regA_odd",  reg_o, exp_reg());
      check("par_even",  par_e, exp_par);
      check("par_odd",   par_o, exp_par);
      check("err_even",  err_e, exp_err_e);
      check("err_odd",   err_o, exp_err_o);
      if (done_e) n_done++;
    end
  end

  // Drives one frame starting at a negedge; returns at the negedge of the
  // done cycle.
  task automatic frame(input logic [W-1:0] d, input logic p, input bit keep_start);
    start = 1'b1;
    @(negedge clock);
    if (!keep_start) start = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      serialin = d[i];
      @(negedge clock);
    end
    serialin = p;
    @(negedge clock);
    $display("frame data=%02h pbit=%0d -> regA=%02h parity=%0d err_even=%0d err_odd=%0d done=%0d",
             d, p, reg_e, par_e, err_e, err_o, done_e);
  endtask

  initial begin
    int n0;
    // Reset state
    #1;
    check("rst_regA", reg_e, 0);
    check("rst_par", par_e, 0);
    check("rst_err", err_e, 0);
    check("rst_done", done_e, 0);
    check("rst_busy", busy_e, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Even parity frame A5
    frame(8'hA5, 1'b0, 1'b0);
    check("a5_regA", reg_e, 8'hA5);
    check("a5_par", par_e, 0);
    check("a5_err", err_e, 0);
    check("a5_done", done_e, 1);
    @(negedge clock);

    // Parity error frame 07
    frame(8'h07, 1'b0, 1'b0);
    check("07_regA", reg_e, 8'h07);
    check("07_par", par_e, 1);
    check("07_err", err_e, 1);
    check("07_err_odd", err_o, 0);
    @(negedge clock);

    // Odd parity frames of 00
    frame(8'h00, 1'b1, 1'b0);
    check("00p1_par_odd", par_o, 0);
    check("00p1_err_odd", err_o, 0);
    @(negedge clock);
    frame(8'h00, 1'b0, 1'b0);
    check("00p0_err_odd", err_o, 1);
    @(negedge clock);

    // start held high through a frame
    n0 = n_done;
    frame(8'h3C, 1'b0, 1'b1);
    check("3c_done", done_e, 1);
    check("3c_regA", reg_e, 8'h3C);
    @(negedge clock);
    check("3c_idle_busy", busy_e, 0);
    check("3c_idle_done", done_e, 0);
    @(negedge clock);
    check("3c_restart_busy", busy_e, 1);
    check("3c_one_pulse", n_done - n0, 1);
    start = 1'b0;
    for (int i = 0; i <= W; i++) begin
      serialin = 1'($urandom);
      @(negedge clock);
    end
    check("3c_second_done", done_e, 1);
    @(negedge clock);

    // Reset after 4 data bits
    n0 = n_done;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serialin = 1'b1;
      @(negedge clock);
    end
    #2 reset_n = 1'b0;
    #1;
    check("arst_regA", reg_e, 0);
    check("arst_par", par_e, 0);
    check("arst_err", err_e, 0);
    check("arst_busy", busy_e, 0);
    check("arst_done", done_e, 0);
    @(negedge clock);
    reset_n = 1'b1;
    check("arst_no_done", n_done - n0, 0);
    frame(8'hFF, 1'b0, 1'b0);
    check("ff_regA", reg_e, 8'hFF);
    check("ff_err", err_e, 0);
    @(negedge clock);

    // Hold after frame 81
    frame(8'h81, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("hold_regA", reg_e, 8'h81);
      check("hold_done", done_e, 0);
    end

    // Randomized traffic, including stray start pulses and async resets
    for (int c = 0; c < 500; c++) begin
      if (!reset_n) reset_n = 1'b1;
      start    = ($urandom_range(0, 3) == 0);
      serialin = 1'($urandom);
      if ($urandom_range(0, 99) == 0) #2 reset_n = 1'b0;
      @(negedge clock);
    end
    reset_n = 1'b1;
    start = 1'b0;
    repeat (W + 4) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_receiver.md
PARITY_RECEIVER -- requirements
Module: parity_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 8: number of data bits per frame, legal range 2 to 16.
REQ-002 SHALL have parameter ODD_PARITY, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: frame-start request, sampled only in IDLE.
REQ-006 SHALL have port serialin, input, 1 bit: serial line carrying data bits MSB first, followed by one parity bit.
REQ-007 SHALL have port registerA, output, DATA_W bits: assembled data word.
REQ-008 SHALL have port parity, output, 1 bit: parity computed over the received data bits.
REQ-009 SHALL have port parity_err, output, 1 bit: received parity bit mismatches the expected value.
REQ-010 SHALL have port done, output, 1 bit: frame-complete pulse.
REQ-011 SHALL have port busy, output, 1 bit: high in SHIFT and PCHK states.

Function
REQ-012 SHALL implement a four-state FSM: IDLE, SHIFT, PCHK, DONE.
REQ-013 In IDLE with start=1 at a rising edge, SHALL move to SHIFT, clear the bit counter and clear the ones counter.
- registerA, parity and parity_err hold their previous values until the first SHIFT edge.
- parity_err is then cleared on that first SHIFT edge.
REQ-014 In SHIFT, each rising edge SHALL:
- shift registerA left by one, inserting serialin at bit 0;
- increment the ones counter when serialin=1;
- increment the bit counter.
REQ-015 After exactly DATA_W SHIFT edges, SHALL move to PCHK; the MSB received first ends in registerA[DATA_W-1].
REQ-016 On the PCHK edge, SHALL:
- sample serialin as the received parity bit;
- set parity = LSB of the ones count (XOR of the data bits);
- set parity_err = received bit XOR (parity XOR ODD_PARITY);
- move to DONE.
REQ-017 In DONE, SHALL assert done=1 for exactly one cycle, then move to IDLE unconditionally.
REQ-018 Frame latency SHALL be fixed:
- start sampled at edge E0;
- data bits sampled at edges E1..E(DATA_W);
- parity bit sampled at edge E(DATA_W+1);
- done high during the cycle after edge E(DATA_W+1).
REQ-019 start SHALL be ignored in SHIFT, PCHK and DONE; no frame restarts mid-frame.
REQ-020 registerA, parity and parity_err SHALL hold their values from the DONE cycle until the first SHIFT edge of the next frame.
REQ-021 The bit counter SHALL be wide enough to count to DATA_W; the ones counter SHALL be wide enough to count to DATA_W without wrap.
REQ-022 An unreachable state encoding SHALL return to IDLE on the next edge with done=0.
REQ-023 busy SHALL be 1 exactly when the state is SHIFT or PCHK; done and busy SHALL never be 1 together.

Reset
REQ-024 reset_n=0 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- registerA to 0, parity to 0, parity_err to 0, done to 0, busy to 0;
- both counters to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame and produce no done pulse.
REQ-026 After reset_n returns to 1, the first rising edge with start=1 SHALL begin a new frame.

Verification
REQ-027 Even parity: start, then serialin 1,0,1,0,0,1,0,1 and parity bit 0 -> registerA=8'hA5, parity=0, parity_err=0, done pulses one cycle after edge E9.
REQ-028 Parity error: start, then data 8'h07 and parity bit 0 -> registerA=8'h07, parity=1, parity_err=1.
REQ-029 Odd parity (ODD_PARITY=1): data 8'h00 with parity bit 1 -> parity=0, parity_err=0; same data with parity bit 0 -> parity_err=1.
REQ-030 Start ignored: start held high throughout a frame of 8'h3C with parity bit 0 -> exactly one done pulse; FSM returns to IDLE for one cycle and restarts only on the next IDLE edge with start=1.
REQ-031 Reset mid-frame: reset_n pulsed low after 4 data bits -> outputs become 0 asynchronously, no done pulse; the next frame 8'hFF with parity bit 0 -> parity_err=0.
REQ-032 Hold: after a frame 8'h81, registerA=8'h81 is held for 10 idle cycles with start=0 and done=0 throughout.
